// File: rtl/num_symbol_serializer_if.sv
// Byte-in / symbol-out bus of num_symbol_serializer.
// master = byte producer side, slave = serializer side.
interface num_symbol_serializer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clear;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    num;
    logic          num_valid;
    logic [LW-1:0] fifo_level;

    modport master (
        output clear, in_data, in_valid,
        input  in_ready, num, num_valid, fifo_level
    );

    modport slave (
        input  clear, in_data, in_valid,
        output in_ready, num, num_valid, fifo_level
    );
endinterface

// File: rtl/num_symbol_serializer.sv
// Byte FIFO feeding a 2-bit symbol shifter; emits 2'b00 with num_valid=0 when idle.
// NUM_SERIALIZER_LSB_FIRST_EN: emit each byte LSB pair first (default MSB pair first).
module num_symbol_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    num_symbol_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [5:0]    r_sh;
    logic [1:0]    r_rem;
    logic [1:0]    r_num;
    logic          r_num_valid;

    logic          w_in_ready;
    logic          w_wr_en;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [7:0]    w_ordered;

    assign w_in_ready = (r_level != LW'(DEPTH));
    assign w_wr_en    = bus.in_valid && w_in_ready && !bus.clear;
    assign w_pop      = (r_rem == 2'd0) && (r_level != '0) && !bus.clear;
    assign w_head     = r_mem[r_rd_ptr];

    // Reorder the head byte so the shifter always emits from its top pair.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pair
`ifdef NUM_SERIALIZER_LSB_FIRST_EN
            assign w_ordered[2*gi +: 2] = w_head[6-2*gi +: 2];
`else
            assign w_ordered[2*gi +: 2] = w_head[2*gi +: 2];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_sh        <= '0;
            r_rem       <= 2'd0;
            r_num       <= 2'b00;
            r_num_valid <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rem       <= 2'd0;
            r_num       <= 2'b00;
            r_num_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (r_rem != 2'd0) begin
                r_num       <= r_sh[5:4];
                r_sh        <= {r_sh[3:0], 2'b00};
                r_rem       <= r_rem - 2'd1;
                r_num_valid <= 1'b1;
            end else if (w_pop) begin
                r_num       <= w_ordered[7:6];
                r_sh        <= w_ordered[5:0];
                r_rem       <= 2'd3;
                r_num_valid <= 1'b1;
            end else begin
                r_num       <= 2'b00;
                r_num_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.num        = r_num;
    assign bus.num_valid  = r_num_valid;
    assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_num_symbol_serializer.sv
// Scoreboard bench for num_symbol_serializer: accepted bytes expand into expected symbols.
module tb_num_symbol_serializer;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    num_symbol_serializer_if #(.DEPTH(DEPTH)) bus ();

    num_symbol_serializer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] sym;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [1:0] sym_log[$];
    int         checks     = 0;
    int         failures   = 0;
    int         cycle      = 0;
    bit         pend_push  = 0;
    bit         pend_flush = 0;
    logic [7:0] pend_byte  = 8'h00;
    bit         saw_full   = 0;
    bit         verbose    = 1;

    always @(posedge clk) cycle <= cycle + 1;

    // i-th symbol emitted for byte b
    function automatic logic [1:0] sym_of(logic [7:0] b, int i);
`ifdef NUM_SERIALIZER_LSB_FIRST_EN
        return 2'((b >> (2*i)) & 8'h03);
`else
        return 2'((b >> (6 - 2*i)) & 8'h03);
`endif
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: apply last cycle's decided write/clear, then compare the outputs of this edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pend_push  = 0;
            pend_flush = 0;
        end else begin
            if (pend_flush) begin
                q.delete();
            end else if (pend_push) begin
                for (int i = 0; i < 4; i++) q.push_back('{sym_of(pend_byte, i), cycle});
            end
            pend_push  = 0;
            pend_flush = 0;

            if (bus.num_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_symbol actual num=%0d required=no symbol (cycle %0d)", bus.num, cycle);
                end else begin
                    mon_e = q.pop_front();
                    check("symbol", int'(bus.num), int'(mon_e.sym));
                    sym_log.push_back(bus.num);
                end
            end else begin
                check("idle_filler", int'(bus.num), 0);
                check("no_bubble", int'(q.size() == 0 || q[0].cyc == cycle), 1);
            end
            check("fifo_level", int'(bus.fifo_level), q.size() / 4);
            check("in_ready", int'(bus.in_ready), int'((q.size() / 4) != DEPTH));
            if (!bus.in_ready) saw_full = 1;

            pend_flush = bus.clear;
            pend_push  = bus.in_valid && ((q.size() / 4) != DEPTH) && !bus.clear;
            pend_byte  = bus.in_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        repeat (n) step();
    endtask

    task automatic write(logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.clear    = 1'b0;
        if (verbose) $display("write byte=%02h at cycle %0d", b, cycle);
        step();
    endtask

    task automatic check_log(string name, logic [1:0] exp_syms[$]);
        check({name, "_count"}, sym_log.size(), exp_syms.size());
        for (int i = 0; i < exp_syms.size(); i++) begin
            if (i < sym_log.size()) check({name, "_sym"}, int'(sym_log[i]), int'(exp_syms[i]));
        end
    endtask

    logic [1:0] exp_syms[$];
    int         rate;

    initial begin
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state, seen before any clock edge.
        #2;
        check("rst_num", int'(bus.num), 0);
        check("rst_num_valid", int'(bus.num_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_fifo_level", int'(bus.fifo_level), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single byte 0x6C
        sym_log.delete();
        write(8'h6C);
        idle(8);
`ifdef NUM_SERIALIZER_LSB_FIRST_EN
        exp_syms = '{2'd0, 2'd3, 2'd2, 2'd1};
`else
        exp_syms = '{2'd1, 2'd2, 2'd3, 2'd0};
`endif
        check_log("t2", exp_syms);

        // Two bytes back to back
        sym_log.delete();
        write(8'h1B);
        write(8'hE4);
        idle(12);
`ifdef NUM_SERIALIZER_LSB_FIRST_EN
        exp_syms = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`else
        exp_syms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
`endif
        check_log("t3", exp_syms);

        // Six consecutive writes: FIFO fills, the 6th is refused
        sym_log.delete();
        saw_full = 0;
        for (int i = 0; i < 6; i++) write(8'h10 + 8'(i));
        idle(30);
        check("t4_saw_full", int'(saw_full), 1);
        check("t4_symbols", sym_log.size(), 20);

        // Clear on the 2nd symbol of 0xFF with two bytes queued, plus a discarded write
        sym_log.delete();
        write(8'hFF);
        write(8'h01);
        write(8'h02);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        step();
        idle(12);
        check("t5_symbols", sym_log.size(), 2);

        // Asynchronous reset in the middle of a byte
        write(8'hA5);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_num_valid", int'(bus.num_valid), 0);
        check("mid_rst_num", int'(bus.num), 0);
        check("mid_rst_fifo_level", int'(bus.fifo_level), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);

        // Randomized traffic with occasional clears
        verbose = 0;
        rate    = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rate = $urandom_range(5, 100);
            bus.in_valid = ($urandom_range(0, 99) < rate);
            bus.in_data  = 8'($urandom);
            bus.clear    = ($urandom_range(0, 99) == 0);
            step();
        end
        idle(4 * (DEPTH + 1) + 8);
        check("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
